vga_palette_ctrl: RTL and testbench
===================================

// Module: vga_palette_ctrl
// PURPOSE
//  Programmable 16-entry 12-bit palette with a pixel lookup stage for the VGA text path.
//  Accepts CPU palette writes through a valid/ready port and buffers them in a small FIFO.
//  Commits buffered writes only while the display is blanking, so visible pixels never tear.
//  Looks up fg/bg indices and drives packed 8-bit R/G/B: fg nibble in [7:4], bg nibble in [3:0].
// PARAMETERS
//  PEND_DEPTH    4   pending-write FIFO depth, power of two, >=2
//  BLINK_FRAMES  16  frames per blink half-period; used only with PALETTE_BLINK_EN
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous, active-high reset
//  wr_valid   in   1   CPU palette write request
//  wr_ready   out  1   FIFO can accept a write: !full
//  wr_index   in   4   palette entry to write
//  wr_rgb     in   12  new entry, {R[3:0],G[3:0],B[3:0]}
//  pend_cnt   out  $clog2(PEND_DEPTH)+1  writes queued, not yet committed
//  blank      in   1   1 = outside active video; commits allowed
//  vsync_pulse in  1   one-cycle pulse at frame start
//  pix_valid  in   1   fg/bg valid this cycle
//  fg         in   4   foreground index
//  bg         in   4   background index
//  rgb_valid  out  1   R/G/B valid
//  R, G, B    out  8   {entry[fg].c, entry[bg].c} per channel
// BEHAVIOUR
//  Reset
//   - All outputs 0 except wr_ready=1. FIFO is emptied and the blink phase is set to "on".
//   - Palette loads defaults for entries 0..15:
//     000 800 F00 F0F 088 080 0F0 0FF 008 808 00F CCC 888 880 FF0 FFF
//   - Reset mid-operation discards all queued writes. Entries already committed are restored to defaults.
//  Write port
//   - A push occurs when wr_valid && wr_ready.
//   - wr_ready is combinational from the occupancy count only. It does not depend on pop in the same cycle.
//  Commit
//   - A pop occurs on any cycle with blank=1 && !empty.
//   - On a pop, the FIFO head is written to the palette at that clock edge. At most one commit per cycle.
//   - Push and pop in the same cycle: both happen and pend_cnt is unchanged.
//   - Queued writes to the same index commit in order; the last one wins.
//   - When blank=0, nothing commits and the FIFO only fills. At full, wr_ready=0.
//  Lookup
//   - Registered, 1-cycle latency: rgb_valid(t+1) = pix_valid(t).
//   - R/G/B update only when pix_valid=1 and hold otherwise.
//   - A lookup in the same cycle as a commit to the same index returns the pre-commit value.
//   - Pointers are log2(PEND_DEPTH) bits and wrap naturally. pend_cnt is 0..PEND_DEPTH.
// CONFIGURATION
//  PALETTE_BLINK_EN defined:
//   - A frame counter counts vsync_pulse events modulo BLINK_FRAMES.
//   - At each wrap, the blink phase toggles.
//   - While the phase is "off", pixels with fg[3]=1 use entry[bg] for the fg nibbles.
//   - The counter and phase reset to 0 / "on".
//  PALETTE_BLINK_EN undefined: no counter is built, vsync_pulse is ignored, and fg is always used directly.
// TESTING
//  - Reset, then pix_valid with fg=2, bg=4 -> next cycle rgb_valid=1, R=F0, G=08, B=08.
//  - blank=0; push idx 15 = 0x123 -> pend_cnt=1 and lookup fg=15 still gives FF/FF/FF.
//    Then blank=1 for 1 cycle -> pend_cnt=0 and fg=15, bg=0 gives R=10, G=20, B=30.
//  - blank=0; push PEND_DEPTH writes -> wr_ready=0 and a 5th wr_valid is not accepted.
//    Then with blank=1, one pop per cycle; wr_ready=1 after the first pop.
//  - FIFO at depth-1, blank=1, push and pop in the same cycle -> pend_cnt unchanged.
//    Two queued writes to idx 3 (0xAAA, then 0x555) -> entry 3 = 0x555.
//  - Assert rst with 3 writes queued and entry 1 already committed as 0xFFF -> pend_cnt=0 and entry 1 = 0x800.
//  - PALETTE_BLINK_EN, BLINK_FRAMES=2, fg=9, bg=0:
//    R/G/B = 80/00/80 for 2 frames, then 00/00/00 for 2 frames, then repeats.
//    fg=1 never changes.

Source files
------------

// File: rtl/vga_palette_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_palette_ctrl                                                |
// | Purpose  : 16-entry x 12-bit programmable palette for the VGA text path.   |
// |            CPU writes are queued in a small FIFO and committed one per     |
// |            cycle, only while the display is blanking, so visible pixels    |
// |            never tear. A registered lookup turns fg/bg indices into packed |
// |            8-bit R/G/B (fg nibble in [7:4], bg nibble in [3:0]).           |
// | Options  : PALETTE_BLINK_EN - when defined, a vsync-driven frame counter   |
// |            toggles a blink phase; during the "off" phase, pixels with      |
// |            fg[3]=1 show the background colour in the fg nibbles.          |
// | Ports    : clk, rst          - clock, synchronous active-high reset        |
// |            wr_valid/ready   - CPU write handshake (ready = FIFO not full)  |
// |            wr_index, wr_rgb - palette entry and {R,G,B} nibbles            |
// |            pend_cnt         - writes queued but not yet committed         |
// |            blank            - 1 outside active video, commits allowed      |
// |            vsync_pulse      - one-cycle frame-start pulse (blink only)     |
// |            pix_valid, fg, bg- lookup request                              |
// |            rgb_valid, R,G,B - lookup result, one cycle later              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_palette_ctrl #(
    parameter int PEND_DEPTH   = 4,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [3:0]                    wr_index,
    input  logic [11:0]                   wr_rgb,
    output logic [$clog2(PEND_DEPTH):0]   pend_cnt,
    input  logic                          blank,
    input  logic                          vsync_pulse,
    input  logic                          pix_valid,
    input  logic [3:0]                    fg,
    input  logic [3:0]                    bg,
    output logic                          rgb_valid,
    output logic [7:0]                    R,
    output logic [7:0]                    G,
    output logic [7:0]                    B
);

    localparam int c_ptr_w = $clog2(PEND_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(PEND_DEPTH);

    // Power-on palette contents.
    function automatic logic [11:0] f_default(input logic [3:0] idx);
        f_default = 12'h000;
        case (idx)
            4'd0:  f_default = 12'h000;
            4'd1:  f_default = 12'h800;
            4'd2:  f_default = 12'hF00;
            4'd3:  f_default = 12'hF0F;
            4'd4:  f_default = 12'h088;
            4'd5:  f_default = 12'h080;
            4'd6:  f_default = 12'h0F0;
            4'd7:  f_default = 12'h0FF;
            4'd8:  f_default = 12'h008;
            4'd9:  f_default = 12'h808;
            4'd10: f_default = 12'h00F;
            4'd11: f_default = 12'hCCC;
            4'd12: f_default = 12'h888;
            4'd13: f_default = 12'h880;
            4'd14: f_default = 12'hFF0;
            4'd15: f_default = 12'hFFF;
            default: f_default = 12'h000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Pending-write FIFO: entries are {index[3:0], rgb[11:0]}
    // ------------------------------------------------------------------
    logic [15:0]        r_fifo_mem [PEND_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic        w_push;
    logic        w_pop;
    logic [15:0] w_head;

    // Ready looks only at occupancy so it never depends on same-cycle pop.
    assign wr_ready = (r_count != c_full_cnt);
    assign w_push   = wr_valid && wr_ready;
    assign w_pop    = blank && (r_count != '0);
    assign w_head   = r_fifo_mem[r_rd_ptr];
    assign pend_cnt = r_count;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {wr_index, wr_rgb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Palette storage; one commit per cycle from the FIFO head.
    // ------------------------------------------------------------------
    logic [11:0] r_pal [16];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_pal[i] <= f_default(4'(i));
            end
        end else if (w_pop) begin
            r_pal[w_head[15:12]] <= w_head[11:0];
        end
    end

    // ------------------------------------------------------------------
    // Foreground selection (blink substitutes bg for fg when enabled)
    // ------------------------------------------------------------------
    logic [3:0] w_fg_sel;

`ifdef PALETTE_BLINK_EN
    localparam int c_frm_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_frm_w-1:0] c_frm_last = c_frm_w'(BLINK_FRAMES - 1);

    logic [c_frm_w-1:0] r_frame_cnt;
    logic               r_blink_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (vsync_pulse) begin
            if (r_frame_cnt == c_frm_last) begin
                r_frame_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_fg_sel = (!r_blink_on && fg[3]) ? bg : fg;
`else
    logic w_unused_vsync;
    assign w_unused_vsync = vsync_pulse;
    assign w_fg_sel       = fg;
`endif

    // ------------------------------------------------------------------
    // Registered lookup. Reads see the palette before any commit on the
    // same edge, so a same-cycle commit returns the old colour.
    // ------------------------------------------------------------------
    logic [11:0] w_fg_c;
    logic [11:0] w_bg_c;

    assign w_fg_c = r_pal[w_fg_sel];
    assign w_bg_c = r_pal[bg];

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_valid <= 1'b0;
            R         <= 8'h00;
            G         <= 8'h00;
            B         <= 8'h00;
        end else begin
            rgb_valid <= pix_valid;
            if (pix_valid) begin
                R <= {w_fg_c[11:8], w_bg_c[11:8]};
                G <= {w_fg_c[7:4],  w_bg_c[7:4]};
                B <= {w_fg_c[3:0],  w_bg_c[3:0]};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_palette_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_palette_ctrl                                             |
// | Purpose  : Self-checking bench for vga_palette_ctrl: directed scenarios    |
// |            followed by random traffic, all compared against a queue +      |
// |            array reference model of the palette and pending writes.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vga_palette_ctrl;

    localparam int PEND_DEPTH   = 4;
    localparam int BLINK_FRAMES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic [2:0]  pend_cnt;
    logic        blank;
    logic        vsync_pulse;
    logic        pix_valid;
    logic [3:0]  fg;
    logic [3:0]  bg;
    logic        rgb_valid;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;

    vga_palette_ctrl #(
        .PEND_DEPTH   (PEND_DEPTH),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_index    (wr_index),
        .wr_rgb      (wr_rgb),
        .pend_cnt    (pend_cnt),
        .blank       (blank),
        .vsync_pulse (vsync_pulse),
        .pix_valid   (pix_valid),
        .fg          (fg),
        .bg          (bg),
        .rgb_valid   (rgb_valid),
        .R           (R),
        .G           (G),
        .B           (B)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    logic [11:0] c_def [16] = '{12'h000, 12'h800, 12'hF00, 12'hF0F,
                                12'h088, 12'h080, 12'h0F0, 12'h0FF,
                                12'h008, 12'h808, 12'h00F, 12'hCCC,
                                12'h888, 12'h880, 12'hFF0, 12'hFFF};
    logic [11:0] m_pal [16];
    logic [15:0] m_q [$];
    int          m_vs;
    logic        e_rv;
    logic [7:0]  e_r;
    logic [7:0]  e_g;
    logic [7:0]  e_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        for (int i = 0; i < 16; i++) m_pal[i] = c_def[i];
        m_vs = 0;
        e_rv = 1'b0;
        e_r  = 8'h00;
        e_g  = 8'h00;
        e_b  = 8'h00;
    endtask

    // Colour a pixel would get from the current model palette.
    function automatic logic [23:0] m_look(input logic [3:0] f, input logic [3:0] b);
        logic [3:0]  fe;
        logic [11:0] cf;
        logic [11:0] cb;
        fe = f;
`ifdef PALETTE_BLINK_EN
        // Phase is "off" during every odd block of BLINK_FRAMES frames.
        if (((m_vs / BLINK_FRAMES) % 2) == 1 && f[3]) fe = b;
`endif
        cf = m_pal[fe];
        cb = m_pal[b];
        return {cf[11:8], cb[11:8], cf[7:4], cb[7:4], cf[3:0], cb[3:0]};
    endfunction

    task automatic idle();
        rst         = 1'b0;
        wr_valid    = 1'b0;
        wr_index    = 4'd0;
        wr_rgb      = 12'h000;
        blank       = 1'b0;
        vsync_pulse = 1'b0;
        pix_valid   = 1'b0;
        fg          = 4'd0;
        bg          = 4'd0;
    endtask

    // Predict the edge from the current inputs, advance one clock, compare.
    task automatic tick();
        logic [23:0] lk;
        logic [15:0] e;
        bit          do_push;
        bit          do_pop;
        if (rst) begin
            m_reset();
        end else begin
            chk("wr_ready_pre", 32'(wr_ready), 32'(m_q.size() < PEND_DEPTH));
            do_push = wr_valid && (m_q.size() < PEND_DEPTH);
            do_pop  = blank && (m_q.size() > 0);
            if (pix_valid) begin
                lk  = m_look(fg, bg);
                e_r = lk[23:16];
                e_g = lk[15:8];
                e_b = lk[7:0];
            end
            e_rv = pix_valid;
            if (do_pop) begin
                e = m_q.pop_front();
                m_pal[e[15:12]] = e[11:0];
            end
            if (do_push) m_q.push_back({wr_index, wr_rgb});
            if (vsync_pulse) m_vs++;
        end
        @(posedge clk);
        #1;
        chk("rgb_valid", 32'(rgb_valid), 32'(e_rv));
        chk("R", 32'(R), 32'(e_r));
        chk("G", 32'(G), 32'(e_g));
        chk("B", 32'(B), 32'(e_b));
        chk("pend_cnt", 32'(pend_cnt), 32'(m_q.size()));
        chk("wr_ready", 32'(wr_ready), 32'(m_q.size() < PEND_DEPTH));
    endtask

    initial begin
        idle();
        m_reset();

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rgb_valid", 32'(rgb_valid), 32'd0);
        chk("rst_R", 32'(R), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_pend", 32'(pend_cnt), 32'd0);

        // Default lookup
        pix_valid = 1'b1; fg = 4'd2; bg = 4'd4;
        tick();
        pix_valid = 1'b0;
        chk("def_valid", 32'(rgb_valid), 32'd1);
        chk("def_R", 32'(R), 32'hF0);
        chk("def_G", 32'(G), 32'h08);
        chk("def_B", 32'(B), 32'h08);

        // Write held off during active video, committed on blanking
        wr_valid = 1'b1; wr_index = 4'd15; wr_rgb = 12'h123;
        tick();
        wr_valid = 1'b0;
        chk("q1_pend", 32'(pend_cnt), 32'd1);
        pix_valid = 1'b1; fg = 4'd15; bg = 4'd15;
        tick();
        pix_valid = 1'b0;
        chk("pre_commit_R", 32'(R), 32'hFF);
        chk("pre_commit_B", 32'(B), 32'hFF);
        blank = 1'b1;
        tick();
        blank = 1'b0;
        chk("commit_pend", 32'(pend_cnt), 32'd0);
        pix_valid = 1'b1; fg = 4'd15; bg = 4'd0;
        tick();
        pix_valid = 1'b0;
        chk("post_commit_R", 32'(R), 32'h10);
        chk("post_commit_G", 32'(G), 32'h20);
        chk("post_commit_B", 32'(B), 32'h30);

        // Fill to full, reject one more, then drain one per cycle
        for (int i = 0; i < PEND_DEPTH; i++) begin
            wr_valid = 1'b1; wr_index = 4'(i + 4); wr_rgb = 12'($urandom);
            tick();
        end
        chk("full_ready", 32'(wr_ready), 32'd0);
        chk("full_pend", 32'(pend_cnt), 32'(PEND_DEPTH));
        wr_index = 4'd11; wr_rgb = 12'h321;
        tick();
        wr_valid = 1'b0;
        chk("reject_pend", 32'(pend_cnt), 32'(PEND_DEPTH));
        blank = 1'b1;
        tick();
        chk("first_pop_ready", 32'(wr_ready), 32'd1);
        chk("first_pop_pend", 32'(pend_cnt), 32'(PEND_DEPTH - 1));
        for (int i = 0; i < PEND_DEPTH - 1; i++) tick();
        blank = 1'b0;
        chk("drained_pend", 32'(pend_cnt), 32'd0);

        // Same-index ordering, then push+pop at depth-1
        wr_valid = 1'b1;
        wr_index = 4'd3; wr_rgb = 12'hAAA; tick();
        wr_index = 4'd3; wr_rgb = 12'h555; tick();
        wr_index = 4'd8; wr_rgb = 12'h0C0; tick();
        chk("dm1_pend", 32'(pend_cnt), 32'(PEND_DEPTH - 1));
        blank = 1'b1; wr_index = 4'd10; wr_rgb = 12'h707;
        tick();
        wr_valid = 1'b0;
        chk("pushpop_pend", 32'(pend_cnt), 32'(PEND_DEPTH - 1));
        for (int i = 0; i < PEND_DEPTH; i++) tick();
        blank = 1'b0;
        pix_valid = 1'b1; fg = 4'd3; bg = 4'd0;
        tick();
        pix_valid = 1'b0;
        chk("last_wins_R", 32'(R), 32'h50);
        chk("last_wins_G", 32'(G), 32'h50);

        // Reset discards queue and restores committed entries
        wr_valid = 1'b1; wr_index = 4'd1; wr_rgb = 12'hFFF; blank = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        blank = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_index = 4'(i + 12); wr_rgb = 12'($urandom);
            tick();
        end
        wr_valid = 1'b0;
        chk("prerst_pend", 32'(pend_cnt), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("postrst_pend", 32'(pend_cnt), 32'd0);
        pix_valid = 1'b1; fg = 4'd1; bg = 4'd0;
        tick();
        pix_valid = 1'b0;
        chk("postrst_R", 32'(R), 32'h80);
        chk("postrst_G", 32'(G), 32'h00);

`ifdef PALETTE_BLINK_EN
        // Blink: fg=9 alternates every BLINK_FRAMES frames, fg=1 never blinks
        for (int k = 1; k <= 4 * BLINK_FRAMES; k++) begin
            vsync_pulse = 1'b1;
            tick();
            vsync_pulse = 1'b0;
            pix_valid = 1'b1; fg = 4'd9; bg = 4'd0;
            tick();
            chk("blink9_R", 32'(R), (((k / BLINK_FRAMES) % 2) == 1) ? 32'h00 : 32'h80);
            chk("blink9_B", 32'(B), (((k / BLINK_FRAMES) % 2) == 1) ? 32'h00 : 32'h80);
            fg = 4'd1;
            tick();
            pix_valid = 1'b0;
            chk("blink1_R", 32'(R), 32'h80);
        end
`endif

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 79) == 0);
            wr_valid    = ($urandom_range(0, 1) == 1);
            wr_index    = 4'($urandom);
            wr_rgb      = 12'($urandom);
            blank       = ($urandom_range(0, 9) < 3);
            vsync_pulse = ($urandom_range(0, 9) == 0);
            pix_valid   = ($urandom_range(0, 9) < 7);
            fg          = 4'($urandom);
            bg          = 4'($urandom);
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
